// File: rtl/pwm_clkdiv_multi.sv
// Multi-channel PWM prescaler: per-channel divided clock, tick strobe and
// shadowed divisor that is applied only at period boundaries, disable or sync.
module pwm_clkdiv_multi #(
    parameter int NCH = 4,
    parameter int DW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NCH-1:0]    en_i,
    input  logic [NCH*DW-1:0] div_i,
    input  logic [NCH-1:0]    load_i,
    input  logic              sync_i,
    output logic [NCH-1:0]    clk_o,
    output logic [NCH-1:0]    tick_o,
    output logic [NCH-1:0]    busy_o
);

    logic [DW-1:0]  cnt_q [NCH];
    logic [DW-1:0]  cnt_d [NCH];
    logic [DW-1:0]  act_q [NCH];
    logic [DW-1:0]  act_d [NCH];
    logic [DW-1:0]  shd_q [NCH];
    logic [DW-1:0]  shd_d [NCH];
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] clk_q, clk_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] tc;
    logic [NCH-1:0] apply;

    always_comb begin
        tc     = '0;
        apply  = '0;
        pend_d = pend_q;
        clk_d  = clk_q;
        tick_d = '0;
        for (int k = 0; k < NCH; k++) begin
            // act != 0 guards the act-1 compare against unsigned wrap.
            tc[k]    = en_i[k] && (act_q[k] != '0) && (cnt_q[k] == act_q[k] - DW'(1));
            apply[k] = pend_q[k] && (sync_i || !en_i[k] || tc[k]);
            // The shadow value applied this cycle is the old one; a coincident
            // load lands in shd and stays pending.
            shd_d[k]  = load_i[k] ? div_i[k*DW +: DW] : shd_q[k];
            pend_d[k] = load_i[k] || (pend_q[k] && !apply[k]);
            act_d[k]  = apply[k] ? shd_q[k] : act_q[k];
            cnt_d[k]  = cnt_q[k];

            if (sync_i) begin
                cnt_d[k] = '0;
                clk_d[k] = 1'b0;
            end else if (!en_i[k]) begin
                if (apply[k]) cnt_d[k] = '0;
            end else if (act_q[k] == '0) begin
                cnt_d[k] = '0;
                clk_d[k] = 1'b0;
            end else if (tc[k]) begin
                cnt_d[k]  = '0;
                clk_d[k]  = ~clk_q[k];
                tick_d[k] = 1'b1;
            end else begin
                cnt_d[k] = cnt_q[k] + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
                act_q[k] <= '0;
                shd_q[k] <= '0;
            end
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= cnt_d[k];
                act_q[k] <= act_d[k];
                shd_q[k] <= shd_d[k];
            end
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign busy_o = pend_q;

endmodule

// File: tb/tb_pwm_clkdiv_multi.sv
// Directed bench for pwm_clkdiv_multi: a cycle table on channel 0 plus
// hand-written sequences for update, gating, sync, zero divisor and reset.
module tb_pwm_clkdiv_multi;

    localparam int NCH = 4;
    localparam int DW  = 16;

    logic              clk_i;
    logic              rst_ni;
    logic [NCH-1:0]    en_i;
    logic [NCH*DW-1:0] div_i;
    logic [NCH-1:0]    load_i;
    logic              sync_i;
    logic [NCH-1:0]    clk_o;
    logic [NCH-1:0]    tick_o;
    logic [NCH-1:0]    busy_o;

    int n_vec;
    int n_err;

    pwm_clkdiv_multi #(.NCH(NCH), .DW(DW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .div_i  (div_i),
        .load_i (load_i),
        .sync_i (sync_i),
        .clk_o  (clk_o),
        .tick_o (tick_o),
        .busy_o (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       en;
        logic       load;
        int         div;
        logic       exp_clk;
        logic       exp_tick;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [NCH*DW-1:0] dvec(int ch, int val);
        logic [NCH*DW-1:0] v;
        v = '0;
        v[ch*DW +: DW] = DW'(val);
        return v;
    endfunction

    task automatic add_vec(logic en, logic load, int div, logic c, logic t, logic b);
        vec_t v;
        v.en = en; v.load = load; v.div = div;
        v.exp_clk = c; v.exp_tick = t; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic drive(logic [NCH-1:0] en, logic [NCH-1:0] load, logic sync,
                         logic [NCH*DW-1:0] div);
        en_i = en; load_i = load; sync_i = sync; div_i = div;
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, 1'b0, '0);
        rst_ni = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        logic [NCH-1:0] exp_clk;
        logic [NCH-1:0] exp_tick;
        n_vec = 0;
        n_err = 0;
        rst_ni = 1'b0;
        drive('0, '0, 1'b0, '0);
        repeat (3) step();
        check("reset_clk", 32'(clk_o), 32'h0);
        check("reset_tick", 32'(tick_o), 32'h0);
        check("reset_busy", 32'(busy_o), 32'h0);
        rst_ni = 1'b1;
        step();

        // Channel 0 cycle table: div 3, div 1, load during tc, div 0.
        add_vec(0, 1, 3, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0);
        add_vec(0, 1, 1, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 0, 1, 0);
        add_vec(1, 0, 0, 1, 1, 0);
        add_vec(1, 1, 2, 0, 1, 1);
        add_vec(1, 0, 0, 1, 1, 0);
        add_vec(1, 0, 0, 1, 0, 0);
        add_vec(1, 0, 0, 0, 1, 0);
        add_vec(0, 1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, 0, 0);
        foreach (vecs[i]) begin
            drive({3'b0, vecs[i].en}, {3'b0, vecs[i].load}, 1'b0, dvec(0, vecs[i].div));
            step();
            check($sformatf("tbl%0d_clk", i), 32'(clk_o), {31'b0, vecs[i].exp_clk});
            check($sformatf("tbl%0d_tick", i), 32'(tick_o), {31'b0, vecs[i].exp_tick});
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), {31'b0, vecs[i].exp_busy});
        end

        // Glitch-free update on ch1: div 5, load 2 at cnt=1.
        do_reset();
        drive(4'b0000, 4'b0010, 1'b0, dvec(1, 5)); step();
        drive(4'b0000, 4'b0000, 1'b0, '0); step();
        for (int i = 1; i <= 14; i++) begin
            drive(4'b0010, (i == 7) ? 4'b0010 : 4'b0000, 1'b0, dvec(1, 2));
            step();
            check($sformatf("upd%0d_tick", i), 32'(tick_o[1]),
                  32'((i == 5) || (i == 10) || (i == 12) || (i == 14)));
            check($sformatf("upd%0d_busy", i), 32'(busy_o[1]), 32'((i >= 7) && (i <= 9)));
        end

        // Zero divisor on ch2 stalls, then div 1 toggles every cycle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(4'b0100, 4'b0000, 1'b0, '0);
            step();
            check($sformatf("zero%0d", i), {30'b0, clk_o[2], tick_o[2]}, 32'h0);
        end
        drive(4'b0000, 4'b0100, 1'b0, dvec(2, 1)); step();
        drive(4'b0000, 4'b0000, 1'b0, '0); step();
        for (int i = 0; i < 6; i++) begin
            drive(4'b0100, 4'b0000, 1'b0, '0);
            step();
            check($sformatf("one%0d", i), {30'b0, clk_o[2], tick_o[2]},
                  {30'b0, (i % 2 == 0), 1'b1});
        end

        // Enable gating on ch3: div 4, drop en at cnt=2 for 10 cycles.
        do_reset();
        drive(4'b0000, 4'b1000, 1'b0, dvec(3, 4)); step();
        drive(4'b0000, 4'b0000, 1'b0, '0); step();
        repeat (2) begin drive(4'b1000, 4'b0000, 1'b0, '0); step(); end
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000, 4'b0000, 1'b0, '0);
            step();
            check($sformatf("gap%0d", i), {30'b0, clk_o[3], tick_o[3]}, 32'h0);
        end
        drive(4'b1000, 4'b0000, 1'b0, '0); step();
        check("reen1", {30'b0, clk_o[3], tick_o[3]}, 32'h0);
        step();
        check("reen2", {30'b0, clk_o[3], tick_o[3]}, 32'h3);

        // Sync alignment: ch0 div 3 and ch1 div 6 started out of phase.
        do_reset();
        drive(4'b0000, 4'b0011, 1'b0, dvec(0, 3) | dvec(1, 6)); step();
        drive(4'b0000, 4'b0000, 1'b0, '0); step();
        drive(4'b0001, 4'b0000, 1'b0, '0); step();
        repeat (4) begin drive(4'b0011, 4'b0000, 1'b0, '0); step(); end
        drive(4'b0011, 4'b0000, 1'b1, '0); step();
        check("sync_clk", 32'(clk_o), 32'h0);
        check("sync_tick", 32'(tick_o), 32'h0);
        exp_clk = '0;
        for (int i = 0; i < 12; i++) begin
            drive(4'b0011, 4'b0000, 1'b0, '0);
            step();
            exp_tick = {2'b00, (i % 6 == 5), (i % 3 == 2)};
            exp_clk  = exp_clk ^ exp_tick;
            check($sformatf("aln%0d_tick", i), 32'(tick_o), 32'(exp_tick));
            check($sformatf("aln%0d_clk", i), 32'(clk_o), 32'(exp_clk));
        end
        drive(4'b0011, 4'b0001, 1'b1, dvec(0, 5)); step();
        check("sync_load_busy", 32'(busy_o), 32'h1);
        check("sync_load_clk", 32'(clk_o), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            drive(4'b0011, 4'b0000, 1'b0, '0);
            step();
            check($sformatf("sl%0d_tick0", i), 32'(tick_o[0]), 32'((i == 3) || (i == 8)));
            check($sformatf("sl%0d_busy0", i), 32'(busy_o[0]), 32'(i < 3));
        end

        // Asynchronous reset mid-period with clk_o=1 and busy_o=1.
        do_reset();
        drive(4'b0000, 4'b0001, 1'b0, dvec(0, 3)); step();
        drive(4'b0000, 4'b0000, 1'b0, '0); step();
        repeat (3) begin drive(4'b0001, 4'b0000, 1'b0, '0); step(); end
        drive(4'b0001, 4'b0001, 1'b0, dvec(0, 7)); step();
        check("pre_rst", {30'b0, clk_o[0], busy_o[0]}, 32'h3);
        drive(4'b0001, 4'b0000, 1'b0, '0);
        rst_ni = 1'b0;
        #1;
        check("arst_clk", 32'(clk_o), 32'h0);
        check("arst_tick", 32'(tick_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 4'b0000, 1'b0, '0);
            step();
            check($sformatf("post_rst%0d", i), {20'b0, clk_o, tick_o, busy_o}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
